// File: rtl/match_pkg.sv
// match_pkg: shared types, geometry helpers and saturating increment for the exact-match engine
package match_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HASH, S_KEY, S_VAL, S_WB} state_e;
  function automatic int unsigned kw_of(input int unsigned key_bytes);
    return key_bytes / 4;
  endfunction
  function automatic int unsigned vw_of(input int unsigned val_bytes);
    return val_bytes / 4;
  endfunction
  function automatic int unsigned ew_of(input int unsigned key_bytes, input int unsigned val_bytes);
    return (key_bytes + val_bytes) / 4;
  endfunction
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/exact_match_nway_hash.sv
// exact_match_nway_hash: byte-serial FNV-1a hash of a 64-bit key, MSB byte first
module exact_match_nway_hash (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [63:0] key_i,
  output logic        ready_o,
  output logic [31:0] hash_o
);
  logic [31:0] h_q, h_d;
  logic [63:0] k_q, k_d;
  logic [3:0]  n_q, n_d;
  logic        rdy_q, rdy_d;
  // fold one key byte per cycle; ready pulses after the eighth byte
  always_comb begin
    h_d   = start_i ? 32'h811c_9dc5 : (n_q != 4'd0) ? (h_q ^ {24'd0, k_q[63:56]}) * 32'h0100_0193 : h_q;
    k_d   = start_i ? key_i : (n_q != 4'd0) ? {k_q[55:0], 8'd0} : k_q;
    n_d   = start_i ? 4'd8 : (n_q != 4'd0) ? n_q - 4'd1 : n_q;
    rdy_d = !start_i && n_q == 4'd1;
  end
  // hash state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q   <= '0;
      k_q   <= '0;
      n_q   <= '0;
      rdy_q <= 1'b0;
    end else begin
      h_q   <= h_d;
      k_q   <= k_d;
      n_q   <= n_d;
      rdy_q <= rdy_d;
    end
  end
  assign ready_o = rdy_q;
  assign hash_o  = h_q;
endmodule

// File: rtl/exact_match_nway.sv
// exact_match_nway: hashed N-way bucket probe with first-match value return and counter RMW
module exact_match_nway
  import match_pkg::*;
#(
  parameter int unsigned KEY_BYTES = 8,
  parameter int unsigned VAL_BYTES = 16,
  parameter int unsigned WAYS      = 4,
  parameter int unsigned IDX_MAX   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  input  logic                   cfg_we_i,
  input  logic [31:0]            cfg_base_i,
  input  logic [4:0]             cfg_idx_bits_i,
  input  logic                   cfg_counter_i,
  output logic                   cfg_err_o,
  output logic                   mem_ce_o,
  output logic                   mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [31:0]            mem_data_o,
  input  logic [31:0]            mem_data_i,
  input  logic                   mem_ready_i,
  output logic                   busy_o,
  output logic                   ready_o,
  output logic                   hit_o,
  output logic [2:0]             way_o,
  output logic [8*VAL_BYTES-1:0] val_o
);
  localparam int unsigned KW       = kw_of(KEY_BYTES);
  localparam int unsigned VW       = vw_of(VAL_BYTES);
  localparam int unsigned EW       = ew_of(KEY_BYTES, VAL_BYTES);
  localparam int unsigned KB       = 8 * KEY_BYTES;
  localparam int unsigned VB       = 8 * VAL_BYTES;
  localparam logic [31:0] ENTRY_B  = 32'(EW * 4);
  localparam logic [31:0] BUCKET_B = 32'(WAYS * EW * 4);
  localparam logic [31:0] KEY_B    = 32'(KW * 4);
  localparam logic [31:0] KSH      = 32'(KB - 32);

  state_e          state_q, state_d;
  logic [KB-1:0]   key_q, key_d;
  logic [31:0]     base_q, base_d;
  logic [4:0]      idx_q, idx_d;
  logic            cnt_q, cnt_d;
  logic [31:0]     entry_q, entry_d;
  logic [7:0]      word_q, word_d;
  logic [2:0]      pw_q, pw_d;
  logic            ce_q, ce_d, we_q, we_d;
  logic [31:0]     addr_q, addr_d, data_q, data_d;
  logic            ready_q, ready_d, hit_q, hit_d, err_q, err_d;
  logic [2:0]      way_q, way_d;
  logic [VB-1:0]   val_q, val_d;
  logic            hash_start, hash_ready;
  logic [31:0]     hash_val, bucket, key_word;
  logic [4:0]      idx_c;
  logic [VB-1:0]   val_ins;
  logic            key_match, last_kw, last_vw, last_way;

  assign hash_start = state_q == S_IDLE && start_i && !cfg_we_i;

  exact_match_nway_hash u_hash (
    .clk     (clk),
    .rst     (rst),
    .start_i (hash_start),
    .key_i   (64'(key_i)),
    .ready_o (hash_ready),
    .hash_o  (hash_val)
  );

  assign idx_c     = (idx_q > 5'(IDX_MAX)) ? 5'(IDX_MAX) : idx_q;
  assign bucket    = base_q + (hash_val & ((32'd1 << idx_c) - 32'd1)) * BUCKET_B;
  assign key_word  = 32'(key_q >> (KSH - 32'({word_q, 5'd0})));
  assign key_match = mem_data_i == key_word;
  assign val_ins   = (VB'(mem_data_i) << (VB - 32)) >> {word_q, 5'd0};
  assign last_kw   = word_q == 8'(KW - 1);
  assign last_vw   = word_q == 8'(VW - 1);
  assign last_way  = pw_q == 3'(WAYS - 1);

  // next-state: walk key words per way, then value words, then the optional counter write
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = hash_start ? S_HASH : S_IDLE;
      S_HASH: state_d = hash_ready ? S_KEY : S_HASH;
      S_KEY:  if (mem_ready_i) state_d = key_match ? (last_kw ? S_VAL : S_KEY) : (last_way ? S_IDLE : S_KEY);
      S_VAL:  if (mem_ready_i && last_vw) state_d = cnt_q ? S_WB : S_IDLE;
      S_WB:   state_d = mem_ready_i ? S_IDLE : S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath and registered outputs; memory address only advances on a completed handshake
  always_comb begin
    key_d   = key_q;
    base_d  = base_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    entry_d = entry_q;
    word_d  = word_q;
    pw_d    = pw_q;
    ce_d    = ce_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    hit_d   = hit_q;
    way_d   = way_q;
    val_d   = val_q;
    ready_d = 1'b0;
    err_d   = cfg_we_i && state_q != S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (cfg_we_i) begin
          base_d = cfg_base_i;
          idx_d  = cfg_idx_bits_i;
          cnt_d  = cfg_counter_i;
        end else if (start_i) begin
          key_d = key_i;
          hit_d = 1'b0;
          way_d = 3'd0;
          val_d = '0;
        end
      end
      S_HASH: if (hash_ready) begin
        entry_d = bucket;
        addr_d  = bucket;
        ce_d    = 1'b1;
        we_d    = 1'b0;
        word_d  = 8'd0;
        pw_d    = 3'd0;
      end
      S_KEY: if (mem_ready_i) begin
        if (!key_match && last_way) begin
          ce_d    = 1'b0;
          ready_d = 1'b1;
        end else if (!key_match) begin
          pw_d    = pw_q + 3'd1;
          entry_d = entry_q + ENTRY_B;
          addr_d  = entry_q + ENTRY_B;
          word_d  = 8'd0;
        end else begin
          addr_d = addr_q + 32'd4;
          word_d = last_kw ? 8'd0 : word_q + 8'd1;
          way_d  = last_kw ? pw_q : way_q;
        end
      end
      S_VAL: if (mem_ready_i) begin
        val_d  = val_q | val_ins;
        addr_d = addr_q + 32'd4;
        word_d = word_q + 8'd1;
        if (last_vw && cnt_q) begin
          we_d   = 1'b1;
          addr_d = entry_q + KEY_B;
          data_d = sat_inc32(val_d[VB-1 -: 32]);
        end else if (last_vw) begin
          ce_d    = 1'b0;
          ready_d = 1'b1;
          hit_d   = 1'b1;
        end
      end
      S_WB: if (mem_ready_i) begin
        ce_d    = 1'b0;
        we_d    = 1'b0;
        ready_d = 1'b1;
        hit_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // all state, config and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= 1'b0;
      entry_q <= '0;
      word_q  <= '0;
      pw_q    <= '0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      way_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      word_q  <= word_d;
      pw_q    <= pw_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      way_q   <= way_d;
      val_q   <= val_d;
    end
  end

  assign cfg_err_o  = err_q;
  assign mem_ce_o   = ce_q;
  assign mem_we_o   = we_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign busy_o     = state_q != S_IDLE;
  assign ready_o    = ready_q;
  assign hit_o      = hit_q;
  assign way_o      = way_q;
  assign val_o      = val_q;
endmodule
